// File: rtl/vending_machine_param.sv
// Coin-credit vending controller: collects coins to PRICE, vends, pays excess back one unit per cycle.
// Optional stock counter with sold_out/restock ports is enabled by defining VM_STOCK_COUNT_EN.
module vending_machine_param #(
    parameter int unsigned COIN_W     = 2,
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned PRICE      = 3,
    parameter int unsigned STOCK_INIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                cancel,
    output logic                out,
    output logic                change_valid,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
`ifdef VM_STOCK_COUNT_EN
    ,
    output logic                sold_out,
    input  logic                restock
`endif
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W:0] PRICE_X    = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                out_q, change_q, reject_q, busy_q;
    logic                reject_d;
    logic [CREDIT_W:0]   sum;
    logic                coin_en, take_coin, stock_ok;

`ifdef VM_STOCK_COUNT_EN
    localparam int unsigned STOCK_W = $clog2(STOCK_INIT + 1);

    logic [STOCK_W-1:0] stock_q;

    // Restock wins over the decrement that would happen in the same VEND cycle.
    always_ff @(posedge clk) begin
        if (rst || restock) begin
            stock_q <= STOCK_W'(STOCK_INIT);
        end else if (state_q == VEND && stock_q != '0) begin
            stock_q <= stock_q - 1'b1;
        end
    end

    assign stock_ok = (stock_q != '0);
    assign sold_out = ~stock_ok;
`else
    assign stock_ok = 1'b1;
`endif

    assign coin_en   = coin_valid && (coin_val != '0);
    assign sum       = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
    assign take_coin = coin_en && (state_q == IDLE || state_q == COLLECT) && !cancel
                       && stock_ok && (sum <= CREDIT_MAX);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = coin_en && !take_coin;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && state_q == COLLECT) begin
                    state_d = CHANGE;
                end else if (take_coin) begin
                    if (sum >= PRICE_X) begin
                        state_d  = VEND;
                        credit_d = CREDIT_W'(sum - PRICE_X);
                    end else begin
                        state_d  = COLLECT;
                        credit_d = CREDIT_W'(sum);
                    end
                end
            end
            VEND: begin
                state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // Each CHANGE cycle pays the unit still shown in credit, so k units give k cycles.
                if (credit_q <= CREDIT_W'(1)) begin
                    state_d = IDLE;
                end
                if (credit_q != '0) begin
                    credit_d = credit_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            out_q    <= 1'b0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            out_q    <= (state_d == VEND);
            change_q <= (state_d == CHANGE);
            reject_q <= reject_d;
            busy_q   <= (state_d == VEND) || (state_d == CHANGE);
        end
    end

    assign out          = out_q;
    assign change_valid = change_q;
    assign coin_reject  = reject_q;
    assign busy         = busy_q;
    assign credit       = credit_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param (PRICE=3, COIN_W=2, CREDIT_W=4).
// Expected output vectors are queued with the cycle they are due and compared at the falling edge.
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       cancel;
    logic       out;
    logic       change_valid;
    logic       coin_reject;
    logic       busy;
    logic [3:0] credit;
`ifdef VM_STOCK_COUNT_EN
    logic       sold_out;
    logic       restock;
`endif

    typedef struct {
        int         due;
        string      tag;
        logic       out;
        logic       cv;
        logic       rej;
        logic       busy;
        logic [3:0] cr;
        int         so;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vending_machine_param #(
        .COIN_W(2),
        .CREDIT_W(4),
        .PRICE(3)
`ifdef VM_STOCK_COUNT_EN
        ,
        .STOCK_INIT(1)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .coin_valid(coin_valid),
        .coin_val(coin_val),
        .cancel(cancel),
        .out(out),
        .change_valid(change_valid),
        .coin_reject(coin_reject),
        .busy(busy),
        .credit(credit)
`ifdef VM_STOCK_COUNT_EN
        ,
        .sold_out(sold_out),
        .restock(restock)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // so: -1 means sold_out is not checked for this cycle.
    task automatic step(input string tag, input bit r, input bit cv, input logic [1:0] val,
                        input bit cn, input bit rs, input bit e_out, input bit e_cv,
                        input bit e_rej, input bit e_busy, input logic [3:0] e_cr, input int e_so);
        exp_t x;
        rst        = r;
        coin_valid = cv;
        coin_val   = val;
        cancel     = cn;
`ifdef VM_STOCK_COUNT_EN
        restock    = rs;
`else
        if (rs) $display("note: restock requested in a build without stock counting");
`endif
        x.due  = cyc + 1;
        x.tag  = tag;
        x.out  = e_out;
        x.cv   = e_cv;
        x.rej  = e_rej;
        x.busy = e_busy;
        x.cr   = e_cr;
        x.so   = e_so;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, ".due"}, cyc, e.due);
            check({e.tag, ".out"}, out, e.out);
            check({e.tag, ".change_valid"}, change_valid, e.cv);
            check({e.tag, ".coin_reject"}, coin_reject, e.rej);
            check({e.tag, ".busy"}, busy, e.busy);
            check({e.tag, ".credit"}, credit, e.cr);
`ifdef VM_STOCK_COUNT_EN
            if (e.so >= 0) check({e.tag, ".sold_out"}, sold_out, e.so[0]);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_val = 2'd0; cancel = 1'b0;
`ifdef VM_STOCK_COUNT_EN
        restock = 1'b0;
`endif
        @(posedge clk);
        #1;
        //          tag       rst cv val cn rs  out cv rej bsy cr  so
        // 1: reset held two cycles
        step("t1.rst0",  1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        step("t1.rst1",  1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        // 2: coin 1 then coin 2 -> exact price, no change
        step("t2.c1",    0, 1, 2'd1, 0, 0,  0, 0, 0, 0, 4'd1, -1);
        step("t2.c2",    0, 1, 2'd2, 0, 0,  1, 0, 0, 1, 4'd0, -1);
        step("t2.idle",  0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, -1);
        step("t2.idle2", 0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, -1);
        // 3: coin 2, coin 2 -> vend then one change unit; cancel during VEND ignored
        step("t3.rst",   1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        step("t3.c1",    0, 1, 2'd2, 0, 0,  0, 0, 0, 0, 4'd2, -1);
        step("t3.c2",    0, 1, 2'd2, 0, 0,  1, 0, 0, 1, 4'd1, -1);
        step("t3.chg",   0, 0, 2'd0, 1, 0,  0, 1, 0, 1, 4'd1, -1);
        step("t3.idle",  0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, -1);
        // 4: coin 2, cancel+coin 1 -> reject, two change cycles; coin during CHANGE rejected
        step("t4.rst",   1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        step("t4.c1",    0, 1, 2'd2, 0, 0,  0, 0, 0, 0, 4'd2, -1);
        step("t4.cxl",   0, 1, 2'd1, 1, 0,  0, 1, 1, 1, 4'd2, -1);
        step("t4.chg2",  0, 1, 2'd1, 0, 0,  0, 1, 1, 1, 4'd1, -1);
        step("t4.idle",  0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, -1);
        // 5: coin during VEND rejected, credit kept; reset during CHANGE
        step("t5.rst",   1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        step("t5.c1",    0, 1, 2'd2, 0, 0,  0, 0, 0, 0, 4'd2, -1);
        step("t5.c2",    0, 1, 2'd2, 0, 0,  1, 0, 0, 1, 4'd1, -1);
        step("t5.vcoin", 0, 1, 2'd1, 0, 0,  0, 1, 1, 1, 4'd1, -1);
        step("t5.rstc",  1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        // 7: zero-value coin, cancel in IDLE, coin 3, two-unit refund aborted by reset
        step("t7.rst",   1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        step("t7.zero",  0, 1, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, -1);
        step("t7.cxl",   0, 0, 2'd0, 1, 0,  0, 0, 0, 0, 4'd0, -1);
        step("t7.c1",    0, 1, 2'd2, 0, 0,  0, 0, 0, 0, 4'd2, -1);
        step("t7.c2",    0, 1, 2'd3, 0, 0,  1, 0, 0, 1, 4'd2, -1);
        step("t7.chg",   0, 0, 2'd0, 0, 0,  0, 1, 0, 1, 4'd2, -1);
        step("t7.rstc",  1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        step("t7.c3",    0, 1, 2'd3, 0, 0,  1, 0, 0, 1, 4'd0, -1);
        step("t7.idle",  0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, -1);
`ifdef VM_STOCK_COUNT_EN
        // 6: single-item stock -> sold out, reject, restock, vend again
        step("t6.rst",   1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 0);
        step("t6.c1",    0, 1, 2'd2, 0, 0,  0, 0, 0, 0, 4'd2, 0);
        step("t6.c2",    0, 1, 2'd1, 0, 0,  1, 0, 0, 1, 4'd0, 0);
        step("t6.so",    0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 1);
        step("t6.rej",   0, 1, 2'd2, 0, 0,  0, 0, 1, 0, 4'd0, 1);
        step("t6.rstk",  0, 0, 2'd0, 0, 1,  0, 0, 0, 0, 4'd0, 0);
        step("t6.c3",    0, 1, 2'd2, 0, 0,  0, 0, 0, 0, 4'd2, 0);
        step("t6.c4",    0, 1, 2'd1, 0, 0,  1, 0, 0, 1, 4'd0, 0);
        step("t6.so2",   0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 4'd0, 1);
`endif
        @(negedge clk);
        #1;
        check("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
